// File: rtl/hilo_muldiv.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO register pair.
// One product or quotient bit is resolved per clock; MTHI/MTLO are served while idle.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div, sign_a, sign_b, b_zero;
  logic [WIDTH-1:0]   opnd;   // multiplicand (mul) or divisor magnitude (div)
  logic [2*WIDTH-1:0] prod;   // {acc, multiplier} for mul, {remainder, dividend/quotient} for div

  logic [WIDTH-1:0]   a_mag, b_mag, addend, diff;
  logic [WIDTH:0]     sum, trial;
  logic               q_bit;
  logic [2*WIDTH-1:0] step, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    a_mag  = (op[0] && reg_a[WIDTH-1]) ? -reg_a : reg_a;
    b_mag  = (op[0] && reg_b[WIDTH-1]) ? -reg_b : reg_b;

    addend = prod[0] ? opnd : '0;
    sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // Restoring step: the partial remainder always stays below the divisor,
    // so a WIDTH-bit difference is exact whenever the trial subtraction succeeds.
    trial  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    q_bit  = (trial >= {1'b0, opnd});
    diff   = trial[WIDTH-1:0] - opnd;

    if (is_div) step = {(q_bit ? diff : trial[WIDTH-1:0]), prod[WIDTH-2:0], q_bit};
    else        step = {sum, prod[WIDTH-1:1]};

    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      // Divide by zero leaves the dividend magnitude as remainder, so the
      // dividend-sign rule restores the raw operand; only the quotient is pinned.
      res_hi = sign_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
      if (b_zero)               res_lo = '1;
      else if (sign_a ^ sign_b) res_lo = -prod[WIDTH-1:0];
      else                      res_lo = prod[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) cnt <= '0;
      else if (state == CALC)     cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);

      if (state == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE) begin
        if (mthi_en) hi <= wr_data;
        if (mtlo_en) lo <= wr_data;
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded at start before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div <= op[1];
      sign_a <= op[0] & reg_a[WIDTH-1];
      sign_b <= op[0] & reg_b[WIDTH-1];
      b_zero <= (reg_b == '0);
      opnd   <= op[1] ? b_mag : a_mag;
      prod   <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
    end else if (state == CALC) begin
      prod   <= step;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed vectors, protocol checks and
// random operations compared against a plain-arithmetic reference model.
module tb_hilo_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, mthi_en, mtlo_en;
  logic [1:0]   op;
  logic [W-1:0] reg_a, reg_b, wr_data;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .reg_a(reg_a), .reg_b(reg_b),
    .mthi_en(mthi_en), .mtlo_en(mtlo_en), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {hi, lo} straight from the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    int     sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    case (o)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: begin sp = longint'(sa) * longint'(sb); return sp; end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb, input bit mt,
                        input logic [63:0] exp);
    logic [31:0] prev_hi, prev_lo;
    int lat, dones;
    bit stable;
    prev_hi = mt ? 32'h55AA_1234 : hi;
    prev_lo = lo;
    start = 1'b1; op = o; reg_a = a; reg_b = b;
    if (mt) begin mthi_en = 1'b1; wr_data = 32'h55AA_1234; end
    tick();
    start = 1'b0; mthi_en = 1'b0;
    lat = 0;
    stable = 1'b1;
    while (!done && lat < 100) begin
      if (hi !== prev_hi || lo !== prev_lo || busy !== 1'b1) stable = 1'b0;
      if (disturb && lat == 5) begin
        start = 1'b1; op = 2'($urandom_range(0, 3)); reg_a = $urandom; reg_b = $urandom;
        mthi_en = 1'b1; mtlo_en = 1'b1; wr_data = $urandom;
      end
      if (disturb && lat == 6) begin
        start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
      end
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_stable_busy"}, 64'(stable), 64'd1);
    check({tag, "_hilo"}, {hi, lo}, exp);
    tick();
    check({tag, "_after"}, {62'd0, busy, done}, 64'd0);
    if (disturb) begin
      dones = 0;
      for (int i = 0; i < 40; i++) begin
        if (done) dones++;
        tick();
      end
      check({tag, "_extra_done"}, 64'(dones), 64'd0);
      check({tag, "_hilo_held"}, {hi, lo}, exp);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b0; start = 1'b0; op = 2'd0; reg_a = '0; reg_b = '0;
    mthi_en = 1'b0; mtlo_en = 1'b0; wr_data = '0;
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_after_reset", {62'd0, busy, done}, 64'd0);

    mtlo_en = 1'b1; wr_data = 32'hA5;
    tick();
    mtlo_en = 1'b0;
    check("mtlo_a5", {hi, lo}, {32'd0, 32'hA5});

    mthi_en = 1'b1; mtlo_en = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    mthi_en = 1'b0; mtlo_en = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});

    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op("mult_neg",  2'd1, 32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("div_neg",   2'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_7_2",  2'd2, 32'd7,         32'd2,         1'b0, 1'b0, {32'd1, 32'd3});
    run_op("divu_zero", 2'd2, 32'h1234,      32'd0,         1'b0, 1'b0, {32'h1234, 32'hFFFF_FFFF});
    run_op("div_ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, {32'd0, 32'h8000_0000});
    run_op("div_neg_zero", 2'd3, 32'hFFFF_FFFB, 32'd0,      1'b0, 1'b0, model(2'd3, 32'hFFFF_FFFB, 32'd0));

    ra = $urandom; rb = $urandom_range(1, 1000);
    run_op("divu_disturb", 2'd2, ra, rb, 1'b1, 1'b0, model(2'd2, ra, rb));
    ra = $urandom; rb = $urandom;
    run_op("mult_mthi_start", 2'd1, ra, rb, 1'b0, 1'b1, model(2'd1, ra, rb));

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (i % 4 == 1) ? 32'($urandom_range(0, 200)) : $urandom;
      rb = (i % 7 == 3) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) - 32'd25 : $urandom);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 1'b0, 1'b0, model(ro, ra, rb));
    end

    start = 1'b1; op = 2'd0; reg_a = 32'h1357_9BDF; reg_b = 32'h2468_ACE0;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("busy_before_reset", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("async_reset_mid_calc", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_after_mid_reset", {62'd0, busy, done}, 64'd0);
    run_op("multu_6_7", 2'd0, 32'd6, 32'd7, 1'b0, 1'b0, {32'd0, 32'd42});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
